m14k_isp_arb: RTL

//  Arbitrates and sequences all ISPRAM accesses: instruction-fetch reads, cache-op
//  tag/data writes and MBIST reads/writes. Drives the ISP_* strobe/address/data bus.

---
 rtl/m14k_isp_arb_if.sv | 52 +++++
 rtl/m14k_isp_arb.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/m14k_isp_arb_if.sv
// m14k_isp_arb_if: requester-side and ISPRAM-side signals of the ISPRAM arbiter.
// slave = arbiter view, master = the requesters/ISPRAM view.
interface m14k_isp_arb_if;
   logic        fetch_req;
   logic [17:0] fetch_addr;
   logic        fetch_gnt;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        cop_req;
   logic        cop_tag;
   logic [17:0] cop_addr;
   logic [31:0] cop_wdata;
   logic        cop_gnt;
   logic        cop_done;
   logic        mb_mode;
   logic        mb_req;
   logic        mb_wr;
   logic [17:0] mb_addr;
   logic [31:0] mb_wdata;
   logic        mb_done;
   logic [17:0] ISP_Addr;
   logic        ISP_RdStr;
   logic        ISP_DataWrStr;
   logic        ISP_TagWrStr;
   logic [31:0] ISP_DataTagValue;
   logic        ISP_Stall;
   logic [31:0] ISP_DataRdValue;
   logic        par_en;
   logic        ISP_ParityEn;
   logic [3:0]  ISP_WPar;
   logic        ISP_ParPresent;
   logic [3:0]  ISP_RPar;
   logic        par_err;

   modport slave (
      input  fetch_req, fetch_addr, cop_req, cop_tag, cop_addr, cop_wdata,
             mb_mode, mb_req, mb_wr, mb_addr, mb_wdata,
             ISP_Stall, ISP_DataRdValue, par_en, ISP_ParPresent, ISP_RPar,
      output fetch_gnt, fetch_valid, fetch_data, cop_gnt, cop_done, mb_done,
             ISP_Addr, ISP_RdStr, ISP_DataWrStr, ISP_TagWrStr, ISP_DataTagValue,
             ISP_ParityEn, ISP_WPar, par_err
   );

   modport master (
      output fetch_req, fetch_addr, cop_req, cop_tag, cop_addr, cop_wdata,
             mb_mode, mb_req, mb_wr, mb_addr, mb_wdata,
             ISP_Stall, ISP_DataRdValue, par_en, ISP_ParPresent, ISP_RPar,
      input  fetch_gnt, fetch_valid, fetch_data, cop_gnt, cop_done, mb_done,
             ISP_Addr, ISP_RdStr, ISP_DataWrStr, ISP_TagWrStr, ISP_DataTagValue,
             ISP_ParityEn, ISP_WPar, par_err
   );
endinterface

// File: rtl/m14k_isp_arb.sv
// m14k_isp_arb: sequences fetch reads, cache-op writes and MBIST accesses onto the ISPRAM bus.
// Define M14K_ISP_PARITY_EN to build byte parity generation and read parity checking.
module m14k_isp_arb #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          gclk_i,
   input  logic          greset_n_i,
   m14k_isp_arb_if.slave bus_io
);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ACC, WAIT} state_t;
   typedef enum logic [1:0] {SRC_FETCH, SRC_COP, SRC_MB} src_t;

   state_t      state_q;
   src_t        src_q;
   logic        rd_q;
   logic [3:0]  starve_q, starve_d;
   logic [17:0] addr_q;
   logic [31:0] dtv_q;
   logic [31:0] fdata_q;
   logic        rdstr_q, dwrstr_q, twrstr_q, fgnt_q, cgnt_q;

   logic        cmpl;
   logic        arb_en;
   logic        win_fetch, win_cop, win_mb, win_any, win_rd;
   logic [17:0] win_addr;
   logic [31:0] win_wdata;

   // C is the first unstalled cycle after the strobe; reset suppresses its completion.
   assign cmpl   = greset_n_i && (state_q == WAIT) && !bus_io.ISP_Stall;
   assign arb_en = (state_q == IDLE) || cmpl;

   always_comb begin
      win_fetch = 1'b0;
      win_cop   = 1'b0;
      win_mb    = 1'b0;
      if (arb_en) begin
         if (bus_io.mb_mode)
            win_mb = bus_io.mb_req;
         else if (bus_io.fetch_req && (!bus_io.cop_req || starve_q == STARVE_LIM))
            win_fetch = 1'b1;
         else
            win_cop = bus_io.cop_req;
      end
   end

   assign win_any   = win_fetch | win_cop | win_mb;
   assign win_rd    = win_fetch | (win_mb & ~bus_io.mb_wr);
   assign win_addr  = win_fetch ? bus_io.fetch_addr : (win_cop ? bus_io.cop_addr : bus_io.mb_addr);
   assign win_wdata = win_cop ? bus_io.cop_wdata : bus_io.mb_wdata;

   always_comb begin
      starve_d = starve_q;
      if (!bus_io.fetch_req || win_fetch)
         starve_d = '0;
      else if (win_cop && starve_q != STARVE_LIM)
         starve_d = starve_q + 4'd1;
   end

`ifdef M14K_ISP_PARITY_EN
   logic [3:0] wpar_q;

   function automatic logic [3:0] byte_par(input logic [31:0] d);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction
`endif

   always_ff @(posedge gclk_i) begin
      if (!greset_n_i) begin
         state_q  <= IDLE;
         src_q    <= SRC_FETCH;
         rd_q     <= 1'b0;
         starve_q <= '0;
         addr_q   <= '0;
         dtv_q    <= '0;
         fdata_q  <= '0;
         rdstr_q  <= 1'b0;
         dwrstr_q <= 1'b0;
         twrstr_q <= 1'b0;
         fgnt_q   <= 1'b0;
         cgnt_q   <= 1'b0;
`ifdef M14K_ISP_PARITY_EN
         wpar_q   <= '0;
`endif
      end else begin
         starve_q <= starve_d;
         rdstr_q  <= 1'b0;
         dwrstr_q <= 1'b0;
         twrstr_q <= 1'b0;
         fgnt_q   <= 1'b0;
         cgnt_q   <= 1'b0;
         if (cmpl && rd_q) fdata_q <= bus_io.ISP_DataRdValue;
         case (state_q)
            ACC:     state_q <= WAIT;
            WAIT:    if (!bus_io.ISP_Stall) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         // A winner overrides the return to IDLE: strobe and gnt appear next cycle.
         if (win_any) begin
            state_q  <= ACC;
            src_q    <= win_fetch ? SRC_FETCH : (win_cop ? SRC_COP : SRC_MB);
            rd_q     <= win_rd;
            addr_q   <= win_addr;
            rdstr_q  <= win_rd;
            dwrstr_q <= (win_cop & ~bus_io.cop_tag) | (win_mb & bus_io.mb_wr);
            twrstr_q <= win_cop & bus_io.cop_tag;
            fgnt_q   <= win_fetch;
            cgnt_q   <= win_cop;
            if (!win_rd) begin
               dtv_q  <= win_wdata;
`ifdef M14K_ISP_PARITY_EN
               wpar_q <= byte_par(win_wdata);
`endif
            end
         end
      end
   end

   assign bus_io.ISP_Addr         = addr_q;
   assign bus_io.ISP_DataTagValue = dtv_q;
   assign bus_io.ISP_RdStr        = rdstr_q;
   assign bus_io.ISP_DataWrStr    = dwrstr_q;
   assign bus_io.ISP_TagWrStr     = twrstr_q;
   assign bus_io.fetch_gnt        = fgnt_q;
   assign bus_io.cop_gnt          = cgnt_q;
   assign bus_io.fetch_data       = fdata_q;
   assign bus_io.fetch_valid      = cmpl && (src_q == SRC_FETCH);
   assign bus_io.cop_done         = cmpl && (src_q == SRC_COP);
   assign bus_io.mb_done          = cmpl && (src_q == SRC_MB);

`ifdef M14K_ISP_PARITY_EN
   assign bus_io.ISP_ParityEn = bus_io.par_en;
   assign bus_io.ISP_WPar     = wpar_q;
   assign bus_io.par_err      = cmpl && rd_q && bus_io.par_en && bus_io.ISP_ParPresent &&
                                (bus_io.ISP_RPar != byte_par(bus_io.ISP_DataRdValue));
`else
   logic unused_par;
   assign unused_par          = ^{bus_io.par_en, bus_io.ISP_ParPresent, bus_io.ISP_RPar};
   assign bus_io.ISP_ParityEn = 1'b0;
   assign bus_io.ISP_WPar     = '0;
   assign bus_io.par_err      = 1'b0;
`endif
endmodule
